fc_sequencer: RTL and testbench
===============================

# fc_sequencer

Controller for the 7-lane fully-connected datapath in the CNN classifier. After a `start` pulse it walks every output neuron and every 7-element input chunk. For each chunk it issues read addresses to the layer and weight buffers, which are synchronous, 1-cycle latency, and feed the datapath directly. It drives the datapath's `signal_accum` aligned to the datapath's 3-register pipeline, captures each neuron's 8-bit `data_out`, and reports the argmax over all neurons as the classification result.

## Interface
- `N_CHUNK`, 16: 7-element input chunks per neuron (≥1).
- `N_OUT`, 10: output neurons (≥1).
- `LA_W`, `$clog2(N_CHUNK)` (min 1): layer address width.
- `WA_W`, `$clog2(N_OUT*N_CHUNK)` (min 1): weight address width.
- `OI_W`, `$clog2(N_OUT)` (min 1): neuron index width.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: begin a pass; sampled only in IDLE.
- `busy`, out, 1: high in RUN and DRAIN.
- `done`, out, 1: one-cycle pulse when `best_idx`/`best_val` are final.
- `mem_rd_en`, out, 1: buffer read strobe.
- `layer_addr`, out, LA_W: chunk index.
- `weight_addr`, out, WA_W: neuron*N_CHUNK + chunk.
- `signal_accum`, out, 1: to datapath; restarts the accumulator.
- `fc_data_out`, in, 8: datapath `data_out`, combinational from its accumulator.
- `res_valid`, out, 1: one-cycle strobe per neuron.
- `res_idx`, out, OI_W: neuron index of the result.
- `res_data`, out, 8: neuron result.
- `best_idx`, out, OI_W: argmax neuron.
- `best_val`, out, 8: argmax value.

## Operation
- **States:**
  - IDLE: `start` moves the FSM to RUN.
  - RUN: one chunk issued per cycle. After chunk N_CHUNK-1 of neuron N_OUT-1 is issued, the FSM moves to DRAIN.
  - DRAIN: a 5-cycle counter. On expiry the FSM moves to DONE.
  - DONE: one cycle, then IDLE.
- **Counters in RUN:**
  - `chunk` 0..N_CHUNK-1 wraps to 0 and increments `neuron`.
  - `weight_addr` is a free incrementer cleared on start; no multiplier.
  - `layer_addr` = `chunk`.
  - `mem_rd_en` = (state==RUN).
- **Tag pipeline:** each issued address carries the tags {first = (chunk==0), last = (chunk==N_CHUNK-1), neuron}.
  - `first` delayed 3 cycles drives `signal_accum`. This covers 1 cycle of memory, the first adder register, and the `add_data4` register.
  - `last` delayed 4 cycles is `cap`. While `cap`=1, `fc_data_out` is the neuron's complete sum.
- **Capture:** on `cap`, the edge registers `res_data`←`fc_data_out` and `res_idx`←the delayed neuron tag, and sets `res_valid` for one cycle.
- **Argmax:** updated on each `res_valid`.
  - The first result of a pass loads unconditionally.
  - A later result replaces the stored value only if strictly greater, so on ties the lower index wins.
  - `best_*` holds until the next `start`.
- **Back-to-back neurons:** the next neuron's `signal_accum` coincides with the previous neuron's `cap` cycle. The datapath value is read in that same cycle, before the clear takes effect, so no bubble is inserted.
- **Ignored/held signals:**
  - `start` during RUN, DRAIN or DONE is ignored.
  - `fc_data_out` outside `cap` cycles is ignored.
  - Outside RUN, addresses hold their last value.
- **Reset values:**
  - All outputs 0.
  - State IDLE.
  - Tag pipeline cleared, so no spurious `signal_accum` or `res_valid`.
- **Reset mid-pass:** the pass is abandoned and no `done` is produced. The datapath has its own reset, so its accumulator may hold stale data; the first `signal_accum` of the next pass discards it.

## Timing
- Let `start` be sampled at the end of cycle 0.
- Address for neuron n, chunk c is issued in cycle a = 1 + n*N_CHUNK + c.
- `signal_accum` for neuron n is high in cycle 1 + n*N_CHUNK + 3.
- For neuron n:
  - `cap` is in cycle (n+1)*N_CHUNK + 4.
  - `res_valid` is in cycle (n+1)*N_CHUNK + 5.
- With T = N_OUT*N_CHUNK:
  - `mem_rd_en` is high in cycles 1..T.
  - `busy` is high in cycles 1..T+5.
  - `done` is high in cycle T+6, with `best_*` final.
  - IDLE is reached in cycle T+7.
- Earliest restart: `start` high in cycle T+7 begins issuing in cycle T+8.
- N_CHUNK=1: `signal_accum` is high every cycle from 4 to T+3, and one result is produced per cycle.

## Test plan
- **Basic pass** (N_CHUNK=2, N_OUT=3, `start` in cycle 0): `weight_addr` 0..5 and `layer_addr` 0,1,0,1,0,1 in cycles 1..6; `signal_accum` in cycles 4, 6, 8; `res_valid` in cycles 7, 9, 11 with `res_idx` 0, 1, 2; `done` in cycle 12.
- **Argmax with tie** (model datapath returning 5, 9, 9): `res_data` 5, 9, 9 in order; `done` with `best_idx`=1 and `best_val`=9.
- **Accumulator isolation:** each neuron's chunks sum to 10, 20, 30 through the real `fullyconnect` instance; `res_data` is exactly the per-neuron value, with no carry-over from the previous neuron.
- **Start while busy:** pulse `start` in cycle 4 of a pass; no effect, and addresses and `done` timing are unchanged.
- **Reset mid-pass:** assert `reset` in cycle 5; the following cycle shows `busy`=0, no `res_valid`, all outputs 0. A new `start` then produces correct results and `done` in cycle T+6 relative to that start.
- **N_CHUNK=1, N_OUT=4:** `signal_accum` high in cycles 4..7; `res_valid` in cycles 6..9 with `res_idx` 0..3; `done` in cycle 10.

Source files
------------

// File: rtl/fc_sequencer_if.sv
// Bundle between fc_sequencer, the 7-lane FC datapath, the layer/weight buffers
// and the host: start/done handshake, buffer reads, accumulator control, results.
interface fc_sequencer_if #(
  parameter int unsigned N_CHUNK = 16,
  parameter int unsigned N_OUT   = 10
);
  localparam int unsigned LA_W = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam int unsigned WA_W = (N_OUT * N_CHUNK > 1) ? $clog2(N_OUT * N_CHUNK) : 1;
  localparam int unsigned OI_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic            start;
  logic            busy;
  logic            done;
  logic            mem_rd_en;
  logic [LA_W-1:0] layer_addr;
  logic [WA_W-1:0] weight_addr;
  logic            signal_accum;
  logic [7:0]      fc_data_out;
  logic            res_valid;
  logic [OI_W-1:0] res_idx;
  logic [7:0]      res_data;
  logic [OI_W-1:0] best_idx;
  logic [7:0]      best_val;

  modport master (
    input  start, fc_data_out,
    output busy, done, mem_rd_en, layer_addr, weight_addr, signal_accum,
           res_valid, res_idx, res_data, best_idx, best_val
  );

  modport slave (
    output start, fc_data_out,
    input  busy, done, mem_rd_en, layer_addr, weight_addr, signal_accum,
           res_valid, res_idx, res_data, best_idx, best_val
  );
endinterface

// File: rtl/fc_sequencer.sv
// Sequencer for the 7-lane FC datapath: walks neurons x chunks, aligns signal_accum
// with the 3-register datapath pipeline, captures each neuron sum and tracks argmax.
module fc_sequencer #(
  parameter int unsigned N_CHUNK = 16,
  parameter int unsigned N_OUT   = 10
) (
  input  logic          clk,
  input  logic          reset,
  fc_sequencer_if.master bus
);
  localparam int unsigned LA_W      = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam int unsigned WA_W      = (N_OUT * N_CHUNK > 1) ? $clog2(N_OUT * N_CHUNK) : 1;
  localparam int unsigned OI_W      = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned DRAIN_CYC = 5;
  localparam int unsigned DC_W      = 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_q;
  logic [LA_W-1:0]       chunk_q;
  logic [OI_W-1:0]       neuron_q;
  logic [WA_W-1:0]       waddr_q;
  logic                  rd_en_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DC_W-1:0]       drain_q;
  logic [2:0]            first_q;
  logic [3:0]            last_q;
  logic [3:0][OI_W-1:0]  nidx_q;
  logic                  res_valid_q;
  logic [OI_W-1:0]       res_idx_q;
  logic [7:0]            res_data_q;
  logic [OI_W-1:0]       best_idx_q;
  logic [7:0]            best_val_q;
  logic                  have_best_q;

  logic last_chunk;
  logic last_neuron;
  logic tag_first_d;
  logic tag_last_d;

  assign last_chunk  = (chunk_q == LA_W'(N_CHUNK - 1));
  assign last_neuron = (neuron_q == OI_W'(N_OUT - 1));
  // Tags of the address issued this cycle; only meaningful while reading.
  assign tag_first_d = rd_en_q && (chunk_q == '0);
  assign tag_last_d  = rd_en_q && last_chunk;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      chunk_q     <= '0;
      neuron_q    <= '0;
      waddr_q     <= '0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      drain_q     <= '0;
      first_q     <= '0;
      last_q      <= '0;
      nidx_q      <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_data_q  <= '0;
      best_idx_q  <= '0;
      best_val_q  <= '0;
      have_best_q <= 1'b0;
    end else begin
      // first: memory + adder reg + add_data4 reg; last: one more so the sum is complete
      first_q     <= {first_q[1:0], tag_first_d};
      last_q      <= {last_q[2:0], tag_last_d};
      nidx_q      <= {nidx_q[2:0], neuron_q};
      res_valid_q <= last_q[3];
      if (last_q[3]) begin
        res_data_q <= bus.fc_data_out;
        res_idx_q  <= nidx_q[3];
      end

      // Strict compare keeps the lower index on ties.
      if (res_valid_q && (!have_best_q || (res_data_q > best_val_q))) begin
        best_val_q <= res_data_q;
        best_idx_q <= res_idx_q;
      end
      if (res_valid_q) begin
        have_best_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q     <= RUN;
            chunk_q     <= '0;
            neuron_q    <= '0;
            waddr_q     <= '0;
            rd_en_q     <= 1'b1;
            busy_q      <= 1'b1;
            have_best_q <= 1'b0;
          end
        end
        RUN: begin
          if (last_chunk && last_neuron) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
            drain_q <= '0;
          end else begin
            waddr_q <= waddr_q + WA_W'(1);
            if (last_chunk) begin
              chunk_q  <= '0;
              neuron_q <= neuron_q + OI_W'(1);
            end else begin
              chunk_q <= chunk_q + LA_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_q == DC_W'(DRAIN_CYC - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + DC_W'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.mem_rd_en    = rd_en_q;
  assign bus.layer_addr   = chunk_q;
  assign bus.weight_addr  = waddr_q;
  assign bus.signal_accum = first_q[2];
  assign bus.res_valid    = res_valid_q;
  assign bus.res_idx      = res_idx_q;
  assign bus.res_data     = res_data_q;
  assign bus.best_idx     = best_idx_q;
  assign bus.best_val     = best_val_q;
endmodule

// File: tb/tb_fc_sequencer.sv
// Directed bench for fc_sequencer: two configurations, each fed by a behavioural
// buffer + 3-register accumulating datapath.
module tb_fc_sequencer;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fc_sequencer_if #(.N_CHUNK(2), .N_OUT(3)) bus_a ();
  fc_sequencer_if #(.N_CHUNK(1), .N_OUT(4)) bus_b ();

  fc_sequencer #(.N_CHUNK(2), .N_OUT(3)) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  fc_sequencer #(.N_CHUNK(1), .N_OUT(4)) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // Datapath model: buffer read, adder reg, add_data4 reg, then accumulator.
  logic [7:0] rom_a [0:7];
  logic [7:0] m_a, p1_a, p2_a, acc_a;
  logic [7:0] rom_b [0:7];
  logic [7:0] m_b, p1_b, p2_b, acc_b;

  always @(posedge clk) begin
    if (bus_a.mem_rd_en) m_a <= rom_a[bus_a.weight_addr];
    p1_a  <= m_a;
    p2_a  <= p1_a;
    acc_a <= bus_a.signal_accum ? p2_a : acc_a + p2_a;
    if (bus_b.mem_rd_en) m_b <= rom_b[bus_b.weight_addr];
    p1_b  <= m_b;
    p2_b  <= p1_b;
    acc_b <= bus_b.signal_accum ? p2_b : acc_b + p2_b;
  end

  assign bus_a.fc_data_out = acc_a;
  assign bus_b.fc_data_out = acc_b;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One pass of config A (T=6); poke>0 pulses start again in that cycle.
  task automatic run_a(input string nm, input int r0, input int r1, input int r2,
                       input int bidx, input int bval, input int poke);
    int  res [3];
    bit  rv;
    bit  rd;
    res = '{r0, r1, r2};
    @(negedge clk) bus_a.start = 1'b1;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(negedge clk);
      bus_a.start = (cyc == poke);
      rd = (cyc >= 1) && (cyc <= 6);
      chk($sformatf("%s.rd_en@%0d", nm, cyc), 32'(bus_a.mem_rd_en), 32'(rd));
      if (rd) begin
        chk($sformatf("%s.waddr@%0d", nm, cyc), 32'(bus_a.weight_addr), cyc - 1);
        chk($sformatf("%s.laddr@%0d", nm, cyc), 32'(bus_a.layer_addr), (cyc - 1) % 2);
      end else begin
        chk($sformatf("%s.waddr_hold@%0d", nm, cyc), 32'(bus_a.weight_addr), 5);
        chk($sformatf("%s.laddr_hold@%0d", nm, cyc), 32'(bus_a.layer_addr), 1);
      end
      chk($sformatf("%s.busy@%0d", nm, cyc), 32'(bus_a.busy), 32'(cyc <= 11));
      chk($sformatf("%s.sacc@%0d", nm, cyc), 32'(bus_a.signal_accum),
          32'(cyc == 4 || cyc == 6 || cyc == 8));
      rv = (cyc == 7 || cyc == 9 || cyc == 11);
      chk($sformatf("%s.rvalid@%0d", nm, cyc), 32'(bus_a.res_valid), 32'(rv));
      if (rv) begin
        chk($sformatf("%s.ridx@%0d", nm, cyc), 32'(bus_a.res_idx), (cyc - 7) / 2);
        chk($sformatf("%s.rdata@%0d", nm, cyc), 32'(bus_a.res_data), res[(cyc - 7) / 2]);
      end
      chk($sformatf("%s.done@%0d", nm, cyc), 32'(bus_a.done), 32'(cyc == 12));
      if (cyc == 12) begin
        chk($sformatf("%s.best_idx", nm), 32'(bus_a.best_idx), bidx);
        chk($sformatf("%s.best_val", nm), 32'(bus_a.best_val), bval);
      end
    end
    bus_a.start = 1'b0;
  endtask

  task automatic check_a_zero(input string nm);
    chk({nm, ".busy"},   32'(bus_a.busy), 0);
    chk({nm, ".done"},   32'(bus_a.done), 0);
    chk({nm, ".rd_en"},  32'(bus_a.mem_rd_en), 0);
    chk({nm, ".waddr"},  32'(bus_a.weight_addr), 0);
    chk({nm, ".laddr"},  32'(bus_a.layer_addr), 0);
    chk({nm, ".sacc"},   32'(bus_a.signal_accum), 0);
    chk({nm, ".rvalid"}, 32'(bus_a.res_valid), 0);
    chk({nm, ".ridx"},   32'(bus_a.res_idx), 0);
    chk({nm, ".rdata"},  32'(bus_a.res_data), 0);
    chk({nm, ".bidx"},   32'(bus_a.best_idx), 0);
    chk({nm, ".bval"},   32'(bus_a.best_val), 0);
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    reset       = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rom_a[i] = 8'd0;
      rom_b[i] = 8'd0;
    end
    repeat (3) @(negedge clk);
    check_a_zero("reset");
    chk("reset.b_busy", 32'(bus_b.busy), 0);
    chk("reset.b_sacc", 32'(bus_b.signal_accum), 0);
    reset = 1'b0;

    // Argmax with a tie: sums 5, 9, 9 -> neuron 1 wins.
    rom_a[0] = 8'd2;  rom_a[1] = 8'd3;  rom_a[2] = 8'd4;
    rom_a[3] = 8'd5;  rom_a[4] = 8'd1;  rom_a[5] = 8'd8;
    run_a("tie", 5, 9, 9, 1, 9, -1);

    // Accumulator isolation: 10, 20, 30.
    rom_a[0] = 8'd4;  rom_a[1] = 8'd6;  rom_a[2] = 8'd15;
    rom_a[3] = 8'd5;  rom_a[4] = 8'd10; rom_a[5] = 8'd20;
    run_a("iso", 10, 20, 30, 2, 30, -1);

    // Start while busy must not disturb the pass.
    run_a("poke", 10, 20, 30, 2, 30, 4);

    // Reset in cycle 5 of a pass.
    @(negedge clk) bus_a.start = 1'b1;
    @(negedge clk) bus_a.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check_a_zero("midrst");
    repeat (3) @(negedge clk);
    check_a_zero("midrst_idle");

    rom_a[0] = 8'd2;  rom_a[1] = 8'd3;  rom_a[2] = 8'd4;
    rom_a[3] = 8'd5;  rom_a[4] = 8'd1;  rom_a[5] = 8'd8;
    run_a("after_rst", 5, 9, 9, 1, 9, -1);

    // N_CHUNK=1, N_OUT=4: one result per cycle; tie between neurons 0 and 2.
    rom_b[0] = 8'd7;  rom_b[1] = 8'd3;  rom_b[2] = 8'd7;  rom_b[3] = 8'd2;
    @(negedge clk) bus_b.start = 1'b1;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      bus_b.start = 1'b0;
      chk($sformatf("b.rd_en@%0d", cyc), 32'(bus_b.mem_rd_en), 32'(cyc <= 4));
      if (cyc <= 4) chk($sformatf("b.waddr@%0d", cyc), 32'(bus_b.weight_addr), cyc - 1);
      chk($sformatf("b.busy@%0d", cyc), 32'(bus_b.busy), 32'(cyc <= 9));
      chk($sformatf("b.sacc@%0d", cyc), 32'(bus_b.signal_accum), 32'(cyc >= 4 && cyc <= 7));
      chk($sformatf("b.rvalid@%0d", cyc), 32'(bus_b.res_valid), 32'(cyc >= 6 && cyc <= 9));
      if (cyc >= 6 && cyc <= 9) begin
        chk($sformatf("b.ridx@%0d", cyc), 32'(bus_b.res_idx), cyc - 6);
        chk($sformatf("b.rdata@%0d", cyc), 32'(bus_b.res_data), 32'(rom_b[cyc - 6]));
      end
      chk($sformatf("b.done@%0d", cyc), 32'(bus_b.done), 32'(cyc == 10));
      if (cyc == 10) begin
        chk("b.best_idx", 32'(bus_b.best_idx), 0);
        chk("b.best_val", 32'(bus_b.best_val), 7);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
